// File: rtl/jedro_1_mem_arb.sv
// Two-to-one memory port arbiter between instruction fetch and load/store units,
// with an in-order grant-ID FIFO for response routing. Define JEDRO_1_ARB_RR_EN for round-robin.
module jedro_1_mem_arb #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,

  input  logic [DATA_WIDTH-1:0] ifu_req_addr_i,
  input  logic [DATA_WIDTH-1:0] ifu_req_data_i,
  input  logic [3:0]            ifu_req_strobe_i,
  input  logic                  ifu_req_write_i,
  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data_o,
  output logic                  ifu_rsp_error_o,
  output logic                  ifu_rsp_valid_o,
  input  logic                  ifu_rsp_ready_i,

  input  logic [DATA_WIDTH-1:0] lsu_req_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_req_data_i,
  input  logic [3:0]            lsu_req_strobe_i,
  input  logic                  lsu_req_write_i,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data_o,
  output logic                  lsu_rsp_error_o,
  output logic                  lsu_rsp_valid_o,
  input  logic                  lsu_rsp_ready_i,

  output logic [DATA_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_data_o,
  output logic [3:0]            mem_req_strobe_o,
  output logic                  mem_req_write_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,

  output logic                  busy_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  logic             lock_vld;
  logic             lock_id;
  logic             sel;
  logic             sel_valid;
  logic             contend_winner;
  logic             can_issue;
  logic             req_fire;
  logic             rsp_fire;
  logic             head;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             id_mem [MAX_OUTSTANDING];

`ifdef JEDRO_1_ARB_RR_EN
  // Names the requester that wins the next contended cycle.
  logic rr_ptr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr <= ID_IFU;
    end else if (req_fire) begin
      rr_ptr <= ~sel;
    end
  end

  assign contend_winner = rr_ptr;
`else
  assign contend_winner = ID_LSU;
`endif

  always_comb begin
    sel = ID_IFU;
    if (lock_vld) begin
      sel = lock_id;
    end else if (ifu_req_valid_i && !lsu_req_valid_i) begin
      sel = ID_IFU;
    end else if (lsu_req_valid_i && !ifu_req_valid_i) begin
      sel = ID_LSU;
    end else if (ifu_req_valid_i && lsu_req_valid_i) begin
      sel = contend_winner;
    end
  end

  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING));
  assign sel_valid = (sel == ID_LSU) ? lsu_req_valid_i : ifu_req_valid_i;

  always_comb begin
    mem_req_addr_o   = ifu_req_addr_i;
    mem_req_data_o   = ifu_req_data_i;
    mem_req_strobe_o = ifu_req_strobe_i;
    mem_req_write_o  = ifu_req_write_i;
    if (sel == ID_LSU) begin
      mem_req_addr_o   = lsu_req_addr_i;
      mem_req_data_o   = lsu_req_data_i;
      mem_req_strobe_o = lsu_req_strobe_i;
      mem_req_write_o  = lsu_req_write_i;
    end
  end

  assign mem_req_valid_o = can_issue && sel_valid;
  assign ifu_req_ready_o = (sel == ID_IFU) && can_issue && mem_req_ready_i;
  assign lsu_req_ready_o = (sel == ID_LSU) && can_issue && mem_req_ready_i;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;

  // A stalled request pins the grant so address/data never change under it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_vld <= 1'b0;
      lock_id  <= ID_IFU;
    end else if (req_fire) begin
      lock_vld <= 1'b0;
    end else if (mem_req_valid_o) begin
      lock_vld <= 1'b1;
      lock_id  <= sel;
    end
  end

  assign head = id_mem[rd_ptr];

  always_comb begin
    ifu_rsp_valid_o = 1'b0;
    lsu_rsp_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    if (count != '0) begin
      if (head == ID_LSU) begin
        lsu_rsp_valid_o = mem_rsp_valid_i;
        mem_rsp_ready_o = lsu_rsp_ready_i;
      end else begin
        ifu_rsp_valid_o = mem_rsp_valid_i;
        mem_rsp_ready_o = ifu_rsp_ready_i;
      end
    end
  end

  assign ifu_rsp_data_o  = mem_rsp_data_i;
  assign ifu_rsp_error_o = mem_rsp_error_i;
  assign lsu_rsp_data_o  = mem_rsp_data_i;
  assign lsu_rsp_error_o = mem_rsp_error_i;
  assign rsp_fire        = mem_rsp_valid_i && mem_rsp_ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (req_fire) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rsp_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (req_fire && !rsp_fire) begin
        count <= count + CNT_W'(1);
      end else if (rsp_fire && !req_fire) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Grant-ID storage carries no reset: entries are only read behind a nonzero count.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      id_mem[wr_ptr] <= sel;
    end
  end

  assign busy_o = (count != '0);

endmodule

// File: tb/tb_jedro_1_mem_arb.sv
// Directed-vector bench for jedro_1_mem_arb (default depth 2, 32-bit data).
`timescale 1ns/1ps
module tb_jedro_1_mem_arb;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] ifu_req_addr_i, ifu_req_data_i;
  logic [3:0]  ifu_req_strobe_i;
  logic        ifu_req_write_i, ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_rsp_data_o;
  logic        ifu_rsp_error_o, ifu_rsp_valid_o, ifu_rsp_ready_i;
  logic [31:0] lsu_req_addr_i, lsu_req_data_i;
  logic [3:0]  lsu_req_strobe_i;
  logic        lsu_req_write_i, lsu_req_valid_i, lsu_req_ready_o;
  logic [31:0] lsu_rsp_data_o;
  logic        lsu_rsp_error_o, lsu_rsp_valid_o, lsu_rsp_ready_i;
  logic [31:0] mem_req_addr_o, mem_req_data_o;
  logic [3:0]  mem_req_strobe_o;
  logic        mem_req_write_o, mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_rsp_data_i;
  logic        mem_rsp_error_i, mem_rsp_valid_i, mem_rsp_ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_mem_arb #(.DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ifu_req_addr_i(ifu_req_addr_i), .ifu_req_data_i(ifu_req_data_i),
    .ifu_req_strobe_i(ifu_req_strobe_i), .ifu_req_write_i(ifu_req_write_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_rsp_data_o(ifu_rsp_data_o), .ifu_rsp_error_o(ifu_rsp_error_o),
    .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_ready_i(ifu_rsp_ready_i),
    .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_data_i(lsu_req_data_i),
    .lsu_req_strobe_i(lsu_req_strobe_i), .lsu_req_write_i(lsu_req_write_i),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_rsp_data_o(lsu_rsp_data_o), .lsu_rsp_error_o(lsu_rsp_error_o),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_strobe_o(mem_req_strobe_o), .mem_req_write_o(mem_req_write_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    ifu_req_addr_i = 32'h0; ifu_req_data_i = 32'h0; ifu_req_strobe_i = 4'h0;
    ifu_req_write_i = 1'b0; ifu_req_valid_i = 1'b0; ifu_rsp_ready_i = 1'b1;
    lsu_req_addr_i = 32'h0; lsu_req_data_i = 32'h0; lsu_req_strobe_i = 4'h0;
    lsu_req_write_i = 1'b0; lsu_req_valid_i = 1'b0; lsu_rsp_ready_i = 1'b1;
    mem_req_ready_i = 1'b1; mem_rsp_data_i = 32'h0; mem_rsp_error_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
  endtask

  logic exp_lsu;

  initial begin
    idle();
    #3;
    chk("rst_mem_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    chk("rst_ifu_rsp_valid", {31'b0, ifu_rsp_valid_o}, 32'd0);
    chk("rst_lsu_rsp_valid", {31'b0, lsu_rsp_valid_o}, 32'd0);
    chk("rst_mem_rsp_ready", {31'b0, mem_rsp_ready_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    #9 rstn_i = 1'b1;
    step();

    // Single IFU read, response two cycles later
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h8000_0000;
    settle();
    chk("t1_req_valid", {31'b0, mem_req_valid_o}, 32'd1);
    chk("t1_req_addr", mem_req_addr_o, 32'h8000_0000);
    chk("t1_ifu_ready", {31'b0, ifu_req_ready_o}, 32'd1);
    chk("t1_lsu_ready", {31'b0, lsu_req_ready_o}, 32'd0);
    step();
    ifu_req_valid_i = 1'b0;
    settle();
    chk("t1_busy", {31'b0, busy_o}, 32'd1);
    step();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0013;
    settle();
    chk("t1_ifu_rsp_valid", {31'b0, ifu_rsp_valid_o}, 32'd1);
    chk("t1_ifu_rsp_data", ifu_rsp_data_o, 32'h0000_0013);
    chk("t1_lsu_rsp_valid", {31'b0, lsu_rsp_valid_o}, 32'd0);
    chk("t1_mem_rsp_ready", {31'b0, mem_rsp_ready_o}, 32'd1);
    step();
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("t1_idle_busy", {31'b0, busy_o}, 32'd0);

    // Contention: both valid, responses one cycle later
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h0000_1000;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h0000_2000;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
      end
      mem_rsp_valid_i = (k > 0);
      mem_rsp_data_i  = 32'hA0 + k;
      settle();
      if (k > 0) begin
        chk($sformatf("t2_rsp%0d_ifu_valid", k), {31'b0, ifu_rsp_valid_o}, {31'b0, ~exp_lsu});
        chk($sformatf("t2_rsp%0d_lsu_valid", k), {31'b0, lsu_rsp_valid_o}, {31'b0, exp_lsu});
      end
      if (k < 4) begin
`ifdef JEDRO_1_ARB_RR_EN
        exp_lsu = (k % 2 == 0);
`else
        exp_lsu = 1'b1;
`endif
        chk($sformatf("t2_grant%0d_addr", k), mem_req_addr_o, exp_lsu ? 32'h2000 : 32'h1000);
        chk($sformatf("t2_grant%0d_lsu_ready", k), {31'b0, lsu_req_ready_o}, {31'b0, exp_lsu});
        chk($sformatf("t2_grant%0d_ifu_ready", k), {31'b0, ifu_req_ready_o}, {31'b0, ~exp_lsu});
      end
      step();
    end
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("t2_drained_busy", {31'b0, busy_o}, 32'd0);

    // Grant lock while memory stalls
    mem_req_ready_i = 1'b0;
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h0000_3000;
    lsu_req_addr_i = 32'h0000_4000;
    settle();
    chk("t3_c1_addr", mem_req_addr_o, 32'h3000);
    chk("t3_c1_valid", {31'b0, mem_req_valid_o}, 32'd1);
    step();
    lsu_req_valid_i = 1'b1;
    settle();
    chk("t3_c2_addr", mem_req_addr_o, 32'h3000);
    chk("t3_c2_lsu_ready", {31'b0, lsu_req_ready_o}, 32'd0);
    step();
    settle();
    chk("t3_c3_addr", mem_req_addr_o, 32'h3000);
    step();
    mem_req_ready_i = 1'b1;
    settle();
    chk("t3_fire_addr", mem_req_addr_o, 32'h3000);
    chk("t3_fire_ifu_ready", {31'b0, ifu_req_ready_o}, 32'd1);
    chk("t3_fire_lsu_ready", {31'b0, lsu_req_ready_o}, 32'd0);
    step();
    ifu_req_valid_i = 1'b0;
    settle();
    chk("t3_lsu_addr", mem_req_addr_o, 32'h4000);
    chk("t3_lsu_ready", {31'b0, lsu_req_ready_o}, 32'd1);
    step();
    lsu_req_valid_i = 1'b0; mem_rsp_valid_i = 1'b1;
    settle();
    chk("t3_rsp0_ifu", {31'b0, ifu_rsp_valid_o}, 32'd1);
    step();
    settle();
    chk("t3_rsp1_lsu", {31'b0, lsu_rsp_valid_o}, 32'd1);
    chk("t3_rsp1_ifu", {31'b0, ifu_rsp_valid_o}, 32'd0);
    step();
    mem_rsp_valid_i = 1'b0;

    // FIFO full
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h5000;
    step();
    ifu_req_addr_i = 32'h5004;
    step();
    ifu_req_addr_i = 32'h5008;
    settle();
    chk("t4_full_valid", {31'b0, mem_req_valid_o}, 32'd0);
    chk("t4_full_ready", {31'b0, ifu_req_ready_o}, 32'd0);
    chk("t4_full_busy", {31'b0, busy_o}, 32'd1);
    step();
    mem_rsp_valid_i = 1'b1;
    settle();
    chk("t4_pop_same_cycle_valid", {31'b0, mem_req_valid_o}, 32'd0);
    chk("t4_pop_rsp_valid", {31'b0, ifu_rsp_valid_o}, 32'd1);
    step();
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("t4_reissue_valid", {31'b0, mem_req_valid_o}, 32'd1);
    chk("t4_reissue_addr", mem_req_addr_o, 32'h5008);
    chk("t4_reissue_ready", {31'b0, ifu_req_ready_o}, 32'd1);
    step();
    ifu_req_valid_i = 1'b0; mem_rsp_valid_i = 1'b1;
    step();
    step();
    mem_rsp_valid_i = 1'b0;
    settle();
    chk("t4_drained_busy", {31'b0, busy_o}, 32'd0);

    // Response backpressure and error, head = LSU
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h6000; lsu_req_write_i = 1'b1;
    lsu_req_data_i = 32'hDEAD_BEEF; lsu_req_strobe_i = 4'hF;
    settle();
    chk("t5_write", {31'b0, mem_req_write_o}, 32'd1);
    chk("t5_wdata", mem_req_data_o, 32'hDEAD_BEEF);
    chk("t5_strobe", {28'b0, mem_req_strobe_o}, 32'hF);
    step();
    lsu_req_valid_i = 1'b0;
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h7000;
    step();
    lsu_rsp_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_error_i = 1'b1;
    settle();
    chk("t5_stall_lsu_valid", {31'b0, lsu_rsp_valid_o}, 32'd1);
    chk("t5_stall_ifu_valid", {31'b0, ifu_rsp_valid_o}, 32'd0);
    chk("t5_stall_mem_ready", {31'b0, mem_rsp_ready_o}, 32'd0);
    step();
    settle();
    chk("t5_count_full", {31'b0, mem_req_valid_o}, 32'd0);
    lsu_rsp_ready_i = 1'b1;
    #1;
    chk("t5_release_mem_ready", {31'b0, mem_rsp_ready_o}, 32'd1);
    chk("t5_lsu_error", {31'b0, lsu_rsp_error_o}, 32'd1);
    step();
    mem_rsp_valid_i = 1'b0; mem_rsp_error_i = 1'b0;
    ifu_req_valid_i = 1'b0;
    settle();
    chk("t5_after_pop_head_ifu", {31'b0, busy_o}, 32'd1);

    // Async reset with two outstanding
    lsu_req_valid_i = 1'b1; lsu_req_write_i = 1'b0;
    step();
    lsu_req_valid_i = 1'b0;
    settle();
    chk("t6_busy_before", {31'b0, busy_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_rst_mem_ready", {31'b0, mem_rsp_ready_o}, 32'd0);
    step();
    rstn_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    settle();
    chk("t6_late_mem_ready", {31'b0, mem_rsp_ready_o}, 32'd0);
    chk("t6_late_ifu_valid", {31'b0, ifu_rsp_valid_o}, 32'd0);
    chk("t6_late_lsu_valid", {31'b0, lsu_rsp_valid_o}, 32'd0);
    step();
    settle();
    chk("t6_late_busy", {31'b0, busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
